// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown timer: FSM encoding, BCD limits and the
// two-digit BCD pair type used for minutes and seconds.
package countdown_pkg;

  typedef logic [7:0] bcd_pair_t;

  localparam logic [1:0] ST_SET   = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
  localparam logic [3:0] BCD_SEC_T_MAX = 4'd5;
  localparam bcd_pair_t  BCD_ZERO      = 8'h00;
  localparam bcd_pair_t  SEC_MAX_BCD   = {BCD_SEC_T_MAX, BCD_DIGIT_MAX};

  // Convert a plain decimal 0..99 into a packed two-digit BCD value.
  function automatic bcd_pair_t to_bcd(input int unsigned v);
    to_bcd = {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/bcd_pair_cnt.sv
// Two-digit BCD register with load, increment wrapping at MAX_BCD back to 00,
// and decrement that wraps 00 to MAX_BCD while flagging a borrow.
module bcd_pair_cnt
  import countdown_pkg::*;
#(
  parameter bcd_pair_t MAX_BCD = 8'h59
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      load,
  input  bcd_pair_t load_val,
  input  logic      inc,
  input  logic      dec,
  output bcd_pair_t q,
  output logic      borrow
);

  bcd_pair_t q_inc;
  bcd_pair_t q_dec;

  always_comb begin
    if (q == MAX_BCD)
      q_inc = BCD_ZERO;
    else if (q[3:0] == BCD_DIGIT_MAX)
      q_inc = {q[7:4] + 4'd1, 4'd0};
    else
      q_inc = {q[7:4], q[3:0] + 4'd1};

    if (q == BCD_ZERO)
      q_dec = MAX_BCD;
    else if (q[3:0] == 4'd0)
      q_dec = {q[7:4] - 4'd1, BCD_DIGIT_MAX};
    else
      q_dec = {q[7:4], q[3:0] - 4'd1};
  end

  assign borrow = dec && (q == BCD_ZERO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q <= BCD_ZERO;
    else if (load)
      q <= load_val;
    else if (inc)
      q <= q_inc;
    else if (dec)
      q <= q_dec;
  end

endmodule

// File: rtl/countdown_ctrl.sv
// Countdown timer core: key-driven MM:SS preset, 1 Hz countdown with pause,
// and a timed alarm window once the count reaches 00:00.
//
//   state    | meaning
//   ST_SET   | editing time with the set keys, waiting for start
//   ST_RUN   | counting down on each CE_1HZ
//   ST_PAUSE | countdown frozen, time held
//   ST_DONE  | reached 00:00, alarm window timing out
module countdown_ctrl
  import countdown_pkg::*;
#(
  parameter int unsigned ALARM_TICKS = 10,
  parameter int unsigned MIN_MAX     = 99
) (
  input  logic       CLK,
  input  logic       CLR_N,
  input  logic       CE_1HZ,
  input  logic       KEY_START,
  input  logic       KEY_MIN,
  input  logic       KEY_SEC,
  input  logic       KEY_CLR,
  output logic [3:0] MIN_T,
  output logic [3:0] MIN_O,
  output logic [3:0] SEC_T,
  output logic [3:0] SEC_O,
  output logic       RUNNING,
  output logic       DONE,
  output logic       ALARM
);

  localparam bcd_pair_t MIN_MAX_BCD = to_bcd(MIN_MAX);

  logic [1:0] state, state_nxt;
  bcd_pair_t  min_q, sec_q, preset_min, preset_sec;
  bcd_pair_t  ld_min_val, ld_sec_val;
  logic [7:0] alarm_cnt;
  logic       alarm_q;
  logic       ld, min_inc, sec_inc, sec_dec, sec_borrow;
  logic       save_preset, arm, disarm, tick;
  logic       time_zero, time_one, any_key;

  assign time_zero = (min_q == BCD_ZERO) && (sec_q == BCD_ZERO);
  assign time_one  = (min_q == BCD_ZERO) && (sec_q == 8'h01);
  assign any_key   = KEY_START || KEY_CLR || KEY_MIN || KEY_SEC;

  always_comb begin
    state_nxt   = state;
    ld          = 1'b0;
    ld_min_val  = preset_min;
    ld_sec_val  = preset_sec;
    min_inc     = 1'b0;
    sec_inc     = 1'b0;
    sec_dec     = 1'b0;
    save_preset = 1'b0;
    arm         = 1'b0;
    disarm      = 1'b0;
    tick        = 1'b0;
    case (state)
      ST_SET: begin
        if (KEY_CLR) begin
          ld         = 1'b1;
          ld_min_val = BCD_ZERO;
          ld_sec_val = BCD_ZERO;
        end else if (KEY_START) begin
          if (!time_zero) begin
            save_preset = 1'b1;
            state_nxt   = ST_RUN;
          end
        end else begin
          min_inc = KEY_MIN;
          sec_inc = KEY_SEC;
        end
      end
      ST_RUN: begin
        if (KEY_CLR) begin
          ld        = 1'b1;
          state_nxt = ST_SET;
        end else begin
          sec_dec = CE_1HZ;
          // Reaching 00:00 wins over a simultaneous pause request.
          if (CE_1HZ && time_one) begin
            arm       = 1'b1;
            state_nxt = ST_DONE;
          end else if (KEY_START) begin
            state_nxt = ST_PAUSE;
          end
        end
      end
      ST_PAUSE: begin
        if (KEY_CLR) begin
          ld        = 1'b1;
          state_nxt = ST_SET;
        end else if (KEY_START) begin
          state_nxt = ST_RUN;
        end
      end
      default: begin
        if (any_key) begin
          ld        = 1'b1;
          disarm    = 1'b1;
          state_nxt = ST_SET;
        end else begin
          tick = CE_1HZ && (alarm_cnt != 8'd0);
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state      <= ST_SET;
      preset_min <= BCD_ZERO;
      preset_sec <= BCD_ZERO;
      alarm_cnt  <= 8'd0;
      alarm_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (save_preset) begin
        preset_min <= min_q;
        preset_sec <= sec_q;
      end
      if (arm) begin
        alarm_cnt <= 8'(ALARM_TICKS);
        alarm_q   <= 1'b1;
      end else if (disarm) begin
        alarm_cnt <= 8'd0;
        alarm_q   <= 1'b0;
      end else if (tick) begin
        alarm_cnt <= alarm_cnt - 8'd1;
        alarm_q   <= (alarm_cnt != 8'd1);
      end
    end
  end

  bcd_pair_cnt #(.MAX_BCD(SEC_MAX_BCD)) u_sec (
    .clk      (CLK),
    .rst_n    (CLR_N),
    .load     (ld),
    .load_val (ld_sec_val),
    .inc      (sec_inc),
    .dec      (sec_dec),
    .q        (sec_q),
    .borrow   (sec_borrow)
  );

  bcd_pair_cnt #(.MAX_BCD(MIN_MAX_BCD)) u_min (
    .clk      (CLK),
    .rst_n    (CLR_N),
    .load     (ld),
    .load_val (ld_min_val),
    .inc      (min_inc),
    .dec      (sec_borrow),
    .q        (min_q),
    .borrow   ()
  );

  assign MIN_T   = min_q[7:4];
  assign MIN_O   = min_q[3:0];
  assign SEC_T   = sec_q[7:4];
  assign SEC_O   = sec_q[3:0];
  assign RUNNING = (state == ST_RUN);
  assign DONE    = (state == ST_DONE);
  assign ALARM   = alarm_q;

endmodule

// File: doc/countdown_ctrl.md
Name: countdown_ctrl

Overview:
Countdown-timer control core that sits directly downstream of the switch debouncers. It consumes their single-cycle key pulses, including auto-repeat pulses, to set a MM:SS preset in BCD. It runs the countdown from a 1 Hz clock-enable, supports pause, resume and clear, and raises a timed alarm at 00:00. Its BCD digit outputs feed the display multiplexer.

Parameters:
ALARM_TICKS, 10, number of CE_1HZ ticks ALARM stays high after reaching 00:00 (1..255)
MIN_MAX, 99, highest settable minute value, BCD-encoded decimal (1..99)

Ports:
CLK  in  1  system clock
CLR_N  in  1  asynchronous active-low reset
CE_1HZ  in  1  one-cycle pulse, once per second
KEY_START  in  1  one-cycle pulse from the start/pause key debouncer
KEY_MIN  in  1  one-cycle pulse from the minute-set key debouncer (auto-repeat allowed)
KEY_SEC  in  1  one-cycle pulse from the second-set key debouncer (auto-repeat allowed)
KEY_CLR  in  1  one-cycle pulse from the clear key debouncer
MIN_T  out  4  minutes tens digit, BCD
MIN_O  out  4  minutes ones digit, BCD
SEC_T  out  4  seconds tens digit, BCD, 0..5
SEC_O  out  4  seconds ones digit, BCD
RUNNING  out  1  high in RUN state
DONE  out  1  high in DONE state
ALARM  out  1  high during the alarm window

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low (CLR_N).
- Reset values: state SET; time and preset both 00:00; RUNNING, DONE and ALARM all 0; alarm counter 0.
- Register timing: all outputs are registered. An input pulse sampled at edge N is visible on the outputs after edge N.
- Key priority within a cycle: KEY_CLR > KEY_START > KEY_MIN/KEY_SEC.
- KEY_MIN and KEY_SEC asserted in the same cycle: both take effect.
- State SET:
  - KEY_MIN: minutes +1 in BCD; after MIN_MAX wraps to 00.
  - KEY_SEC: seconds +1 in BCD; after 59 wraps to 00; no carry into minutes.
  - KEY_CLR: time := 00:00.
  - KEY_START with time ≠ 00:00: preset := time, go to RUN.
  - KEY_START with time = 00:00: ignored, stay in SET.
  - CE_1HZ: ignored.
- State RUN:
  - CE_1HZ: decrement time by one second in BCD (SS 00 borrows: SS := 59, MM -1).
  - If the decrement yields 00:00: go to DONE on the same edge; alarm counter := ALARM_TICKS; ALARM := 1.
  - KEY_START: go to PAUSE.
  - CE_1HZ and KEY_START in the same cycle: decrement is applied, then PAUSE. If the decrement hits 00:00, DONE takes precedence over PAUSE.
  - KEY_MIN/KEY_SEC: ignored.
  - KEY_CLR: time := preset, go to SET.
- State PAUSE:
  - CE_1HZ: ignored; time held.
  - KEY_START: go to RUN.
  - KEY_CLR: time := preset, go to SET.
  - Set keys: ignored.
- State DONE:
  - Time held at 00:00.
  - Each CE_1HZ decrements the alarm counter while it is nonzero.
  - ALARM is low once the counter reaches 0 (exactly ALARM_TICKS ticks high).
  - Any of KEY_START, KEY_CLR, KEY_MIN or KEY_SEC: ALARM := 0, time := preset, go to SET. That key's own set/start effect is not applied.
- Output flags: RUNNING = (state == RUN). DONE = (state == DONE).
- Digit invariants: digits are never outside BCD range, and SEC_T ≤ 5 at all times.
- Reset mid-operation: asynchronous return to the reset values regardless of state; no pending pulse survives reset.

Decomposition:
- Package countdown_pkg:
  - state encoding (SET=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3)
  - BCD constants (digit max 9, SEC_T max 5)
  - 8-bit BCD pair type
- Sub-module bcd_pair_cnt:
  - 8-bit two-digit BCD register with load, inc-with-wrap (parameter MAX) and dec-with-borrow-out.
  - Instantiated once for minutes (MAX=MIN_MAX) and once for seconds (MAX=59).
  - Seconds borrow-out drives the minutes decrement.
- The FSM, preset register and alarm counter live in countdown_ctrl.

Test Plan:
1. Reset, 3×KEY_MIN, 5×KEY_SEC → 03:05 (MIN_O=3, SEC_O=5); 60 further KEY_SEC → 03:05 again (wrap without carry).
2. Set 00:02, KEY_START, 2×CE_1HZ → RUNNING=1 then 00:01, then 00:00 with DONE=1, ALARM=1 on the same edge. ALARM falls after exactly ALARM_TICKS further CE_1HZ; KEY_START → SET showing 00:02.
3. Set 01:00, start, one CE_1HZ → 00:59 (borrow). KEY_START → PAUSE; 3×CE_1HZ → still 00:59. KEY_START → RUN.
4. Time 00:00 in SET, KEY_START → stays SET, RUNNING=0. KEY_START + KEY_CLR same cycle from RUN at 00:40 (preset 01:00) → SET, 01:00.
5. Run at 00:01, CE_1HZ and KEY_START in the same cycle → DONE (not PAUSE), 00:00.
6. CLR_N pulled low mid-RUN at 12:34, asynchronously between edges → outputs 00:00, RUNNING=0, ALARM=0 before the next CLK edge.
